alu_cmd_driver: RTL and testbench

Command-side initiator for the 128-bit pipelined ALU. It accepts operation requests over a valid/ready stream, drives the ALU's opcode/operand/shift ports, and tracks each issued operation through the ALU's fixed latency. It captures result and flags at the right cycle into a response FIFO, tags them, and returns them in issue order over a second valid/ready stream. It sits between the instruction/test sequencer and the ALU datapath.

---
 rtl/alu_cmd_driver.sv | 205 ++++++++++++++++++++
 tb/tb_alu_cmd_driver.sv | 543 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_driver.sv
// Command-side initiator for the pipelined ALU: issues operations, tracks them through
// the fixed ALU latency and returns tagged results with locally derived flags in issue order.

package alu_cmd_driver_pkg;
    localparam int unsigned OPC_W   = 4;
    localparam int unsigned TAG_W   = 4;
    localparam int unsigned SHIFT_W = 5;
    localparam int unsigned FLAGS_W = 4;
    localparam int unsigned CNT16_W = 16;

    localparam logic [OPC_W-1:0] OP_ADD = 4'd0;
    localparam logic [OPC_W-1:0] OP_SUB = 4'd1;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [OPC_W-1:0] opcode;
        logic             a_msb;
        logic             b_msb;
    } track_slot_t;
endpackage

module alu_cmd_driver
    import alu_cmd_driver_pkg::*;
#(
    parameter int unsigned WIDTH       = 128,
    parameter int unsigned ALU_LATENCY = 2,
    parameter int unsigned FIFO_DEPTH  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [OPC_W-1:0]   cmd_opcode,
    input  logic [WIDTH-1:0]   cmd_a,
    input  logic [WIDTH-1:0]   cmd_b,
    input  logic [SHIFT_W-1:0] cmd_shift,
    input  logic [TAG_W-1:0]   cmd_tag,
    output logic [OPC_W-1:0]   alu_opcode,
    output logic [WIDTH-1:0]   alu_input1,
    output logic [WIDTH-1:0]   alu_input2,
    output logic [SHIFT_W-1:0] alu_shiftValue,
    input  logic [WIDTH-1:0]   alu_result,
    input  logic               alu_carryFlag,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [WIDTH-1:0]   rsp_result,
    output logic [FLAGS_W-1:0] rsp_flags,
    output logic [TAG_W-1:0]   rsp_tag,
    output logic [OPC_W-1:0]   rsp_opcode,
    output logic [CNT16_W-1:0] issue_count
);

    localparam int unsigned STAGES = ALU_LATENCY + 1;
    localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef struct packed {
        logic [WIDTH-1:0]   result;
        logic [FLAGS_W-1:0] flags;
        logic [TAG_W-1:0]   tag;
        logic [OPC_W-1:0]   opcode;
    } rsp_entry_t;

    logic               r_cmd_ready;
    logic [CNT_W-1:0]   r_credit;
    logic [CNT16_W-1:0] r_issue_count;
    logic [OPC_W-1:0]   r_alu_opcode;
    logic [WIDTH-1:0]   r_alu_input1;
    logic [WIDTH-1:0]   r_alu_input2;
    logic [SHIFT_W-1:0] r_alu_shift;
    track_slot_t        r_track [STAGES];
    rsp_entry_t         r_fifo  [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;

    logic               w_issue;
    logic               w_pop;
    logic               w_fifo_wr;
    logic               w_is_add;
    logic               w_is_sub;
    logic               w_r_msb;
    logic               w_overflow;
    logic [CNT_W-1:0]   w_credit_next;
    track_slot_t        w_last;
    rsp_entry_t         w_wr_entry;

    assign w_issue   = cmd_valid && r_cmd_ready;
    assign rsp_valid = (r_count != '0);
    assign w_pop     = rsp_valid && rsp_ready;

    // Credit covers in-flight slots plus FIFO entries, so the FIFO cannot overflow.
    always_comb begin
        w_credit_next = r_credit;
        if (w_issue && !w_pop) begin
            w_credit_next = r_credit + CNT_W'(1);
        end else if (!w_issue && w_pop) begin
            w_credit_next = r_credit - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_credit      <= '0;
            r_cmd_ready   <= 1'b1;
            r_issue_count <= '0;
        end else begin
            r_credit    <= w_credit_next;
            r_cmd_ready <= (w_credit_next < DEPTH_C);
            if (w_issue) begin
                r_issue_count <= r_issue_count + CNT16_W'(1);
            end
        end
    end

    // ALU drive: the accepted command, otherwise an all-zero bubble.
    always_ff @(posedge clk) begin
        if (!rst || !w_issue) begin
            r_alu_opcode <= '0;
            r_alu_input1 <= '0;
            r_alu_input2 <= '0;
            r_alu_shift  <= '0;
        end else begin
            r_alu_opcode <= cmd_opcode;
            r_alu_input1 <= cmd_a;
            r_alu_input2 <= cmd_b;
            r_alu_shift  <= cmd_shift;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                r_track[i] <= '0;
            end
        end else begin
            r_track[0] <= w_issue ? {1'b1, cmd_tag, cmd_opcode, cmd_a[WIDTH-1], cmd_b[WIDTH-1]}
                                  : track_slot_t'('0);
            for (int unsigned i = 1; i < STAGES; i++) begin
                r_track[i] <= r_track[i-1];
            end
        end
    end

    // Flags formed at capture time from the ALU result and the tracked operand MSBs.
    always_comb begin
        w_last     = r_track[STAGES-1];
        w_fifo_wr  = w_last.valid;
        w_is_add   = (w_last.opcode == OP_ADD);
        w_is_sub   = (w_last.opcode == OP_SUB);
        w_r_msb    = alu_result[WIDTH-1];
        w_overflow = 1'b0;
        if (w_is_add) begin
            w_overflow = (w_last.a_msb == w_last.b_msb) && (w_r_msb != w_last.a_msb);
        end else if (w_is_sub) begin
            w_overflow = (w_last.a_msb != w_last.b_msb) && (w_r_msb != w_last.a_msb);
        end
        w_wr_entry.result = alu_result;
        w_wr_entry.flags  = {(w_is_add || w_is_sub) && alu_carryFlag,
                             (alu_result == '0), w_overflow, w_r_msb};
        w_wr_entry.tag    = w_last.tag;
        w_wr_entry.opcode = w_last.opcode;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                r_fifo[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_fifo_wr) begin
                r_fifo[r_wr_ptr] <= w_wr_entry;
                r_wr_ptr         <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_fifo_wr, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    a_no_fifo_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(w_fifo_wr && (r_count == DEPTH_C)));

    assign cmd_ready      = r_cmd_ready;
    assign issue_count    = r_issue_count;
    assign alu_opcode     = r_alu_opcode;
    assign alu_input1     = r_alu_input1;
    assign alu_input2     = r_alu_input2;
    assign alu_shiftValue = r_alu_shift;
    assign rsp_result     = r_fifo[r_rd_ptr].result;
    assign rsp_flags      = r_fifo[r_rd_ptr].flags;
    assign rsp_tag        = r_fifo[r_rd_ptr].tag;
    assign rsp_opcode     = r_fifo[r_rd_ptr].opcode;

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Bench for alu_cmd_driver: a two-stage ALU stand-in plus a response model built from
// plain arithmetic, exercised by directed and randomized scenarios.

module tb_alu_cmd_driver;
    localparam int W     = 128;
    localparam int LAT   = 2;
    localparam int DEPTH = 8;

    typedef struct packed {
        logic [W-1:0] result;
        logic [3:0]   flags;
        logic [3:0]   tag;
        logic [3:0]   opcode;
    } rsp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [3:0]   cmd_opcode;
    logic [W-1:0] cmd_a;
    logic [W-1:0] cmd_b;
    logic [4:0]   cmd_shift;
    logic [3:0]   cmd_tag;
    logic [3:0]   alu_opcode;
    logic [W-1:0] alu_input1;
    logic [W-1:0] alu_input2;
    logic [4:0]   alu_shiftValue;
    logic [W-1:0] alu_result;
    logic         alu_carryFlag;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_result;
    logic [3:0]   rsp_flags;
    logic [3:0]   rsp_tag;
    logic [3:0]   rsp_opcode;
    logic [15:0]  issue_count;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   model_credit = 0;
    int   n_both = 0;
    rsp_t obs_q[$];
    rsp_t exp_q[$];
    int   iss_cyc_q[$];
    int   pop_cyc_q[$];
    logic [W:0] alu_s1, alu_s2;

    alu_cmd_driver #(.WIDTH(W), .ALU_LATENCY(LAT), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_shift(cmd_shift), .cmd_tag(cmd_tag),
        .alu_opcode(alu_opcode), .alu_input1(alu_input1), .alu_input2(alu_input2),
        .alu_shiftValue(alu_shiftValue), .alu_result(alu_result), .alu_carryFlag(alu_carryFlag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_flags(rsp_flags), .rsp_tag(rsp_tag), .rsp_opcode(rsp_opcode),
        .issue_count(issue_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ALU behaviour: {carry, result}
    function automatic logic [W:0] alu_fn(input logic [3:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b, input logic [4:0] sh);
        logic [W-1:0] r;
        logic         c;
        c = 1'b0;
        case (op)
            4'd0: {c, r} = {1'b0, a} + {1'b0, b};
            4'd1: begin r = a - b; c = (a < b); end
            4'd2: r = a * b;
            4'd3: r = a ^ b;
            4'd4: r = W'(a < b);
            4'd5: r = a << sh;
            4'd6: r = W'($signed(a) < $signed(b));
            4'd7: r = (b == '0) ? '0 : a / b;
            4'd8: r = a >> sh;
            4'd9: r = (a < b) ? a : b;
            default: r = '0;
        endcase
        return {c, r};
    endfunction

    always @(posedge clk) begin
        alu_s1 <= alu_fn(alu_opcode, alu_input1, alu_input2, alu_shiftValue);
        alu_s2 <= alu_s1;
    end
    assign alu_result    = alu_s2[W-1:0];
    assign alu_carryFlag = alu_s2[W];

    // Expected response from arithmetic on the operands themselves.
    function automatic rsp_t ref_rsp(input logic [3:0] op, input logic [W-1:0] a,
                                     input logic [W-1:0] b, input logic [4:0] sh,
                                     input logic [3:0] tag);
        rsp_t       e;
        logic [W:0] u;
        logic [W:0] s;
        logic       carry, ovf;
        logic [W:0] full;
        full     = alu_fn(op, a, b, sh);
        e.result = full[W-1:0];
        carry = 1'b0;
        ovf   = 1'b0;
        if (op == 4'd0) begin
            u = {1'b0, a} + {1'b0, b};
            carry = u[W];
            s = {a[W-1], a} + {b[W-1], b};
            ovf = (s[W] != s[W-1]);
        end else if (op == 4'd1) begin
            carry = (a < b);
            s = {a[W-1], a} - {b[W-1], b};
            ovf = (s[W] != s[W-1]);
        end
        e.flags  = {carry, (e.result == '0), ovf, e.result[W-1]};
        e.tag    = tag;
        e.opcode = op;
        return e;
    endfunction

    // Records every handshake that the coming rising edge will complete.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                exp_q.delete();
                model_credit = 0;
            end else begin
                if (cmd_valid && cmd_ready) begin
                    exp_q.push_back(ref_rsp(cmd_opcode, cmd_a, cmd_b, cmd_shift, cmd_tag));
                    iss_cyc_q.push_back(cyc + 1);
                    model_credit++;
                end
                if (rsp_valid && rsp_ready) begin
                    obs_q.push_back({rsp_result, rsp_flags, rsp_tag, rsp_opcode});
                    pop_cyc_q.push_back(cyc + 1);
                    model_credit--;
                end
                if (cmd_valid && cmd_ready && rsp_valid && rsp_ready) n_both++;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic clear_q();
        obs_q.delete();
        exp_q.delete();
        iss_cyc_q.delete();
        pop_cyc_q.delete();
        n_both = 0;
    endtask

    task automatic set_cmd(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [4:0] sh, input logic [3:0] tag);
        cmd_opcode = op;
        cmd_a      = a;
        cmd_b      = b;
        cmd_shift  = sh;
        cmd_tag    = tag;
    endtask

    task automatic set_rand_cmd(input logic [3:0] tag);
        set_cmd(4'($urandom_range(0, 15)), rand128(), rand128(), 5'($urandom_range(0, 31)), tag);
    endtask

    task automatic send_cmd(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [4:0] sh, input logic [3:0] tag);
        int n;
        n = 0;
        set_cmd(op, a, b, sh, tag);
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: cmd_ready stayed 0 for %0d cycles", n);
        end
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic apply_reset();
        rst       = 1'b0;
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        clear_q();
    endtask

    task automatic drain();
        int n;
        n = 0;
        rsp_ready = 1'b1;
        while ((rsp_valid || obs_q.size() < exp_q.size()) && n < 100) begin
            tick();
            n++;
        end
        tick();
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({cmd_ready, rsp_valid, issue_count} !== {1'b1, 1'b0, 16'd0}) begin
            errors++;
            $display("FAIL reset_ctrl: got ready=%b valid=%b count=%0d expected 1 0 0",
                     cmd_ready, rsp_valid, issue_count);
        end
        checks++;
        if ({alu_opcode, alu_input1, alu_input2, alu_shiftValue} !== '0) begin
            errors++;
            $display("FAIL reset_alu: got op=%h a=%h b=%h sh=%h expected all 0",
                     alu_opcode, alu_input1, alu_input2, alu_shiftValue);
        end
        checks++;
        if ({rsp_result, rsp_flags, rsp_tag, rsp_opcode} !== '0) begin
            errors++;
            $display("FAIL reset_rsp: got res=%h flags=%b tag=%h op=%h expected all 0",
                     rsp_result, rsp_flags, rsp_tag, rsp_opcode);
        end
    endtask

    task automatic test_add_carry();
        int lat;
        logic [W-1:0] ones;
        ones = '1;
        rsp_ready = 1'b1;
        send_cmd(4'd0, ones, W'(1), 5'd0, 4'd3);
        lat = 0;
        while (!rsp_valid && lat < 10) begin
            tick();
            lat++;
        end
        checks++;
        if (lat !== LAT + 1) begin
            errors++;
            $display("FAIL add_latency: got %0d cycles expected %0d", lat, LAT + 1);
        end
        checks++;
        if ({rsp_result, rsp_flags, rsp_tag} !== {W'(0), 4'b1100, 4'd3}) begin
            errors++;
            $display("FAIL add_carry: got res=%h flags=%b tag=%0d expected 0 1100 3",
                     rsp_result, rsp_flags, rsp_tag);
        end
        drain();
    endtask

    task automatic test_sub();
        logic [W-1:0] min_neg;
        logic [W-1:0] max_pos;
        logic [W-1:0] ones;
        int n;
        min_neg = {1'b1, {(W-1){1'b0}}};
        max_pos = {1'b0, {(W-1){1'b1}}};
        ones    = '1;
        clear_q();
        rsp_ready = 1'b1;
        send_cmd(4'd1, min_neg, W'(1), 5'd0, 4'd5);
        checks++;
        if ({alu_opcode, alu_input1, alu_input2} !== {4'd1, min_neg, W'(1)}) begin
            errors++;
            $display("FAIL alu_drive: got op=%h a=%h b=%h expected 1 %h 1",
                     alu_opcode, alu_input1, alu_input2, min_neg);
        end
        send_cmd(4'd1, W'(1), W'(2), 5'd0, 4'd6);
        n = 0;
        while (obs_q.size() < 2 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (obs_q.size() !== 2) begin
            errors++;
            $display("FAIL sub_count: got %0d responses expected 2", obs_q.size());
        end else begin
            checks++;
            if ({obs_q[0].result, obs_q[0].flags} !== {max_pos, 4'b0010}) begin
                errors++;
                $display("FAIL sub_overflow: got res=%h flags=%b expected %h 0010",
                         obs_q[0].result, obs_q[0].flags, max_pos);
            end
            checks++;
            if ({obs_q[1].result, obs_q[1].flags} !== {ones, 4'b1001}) begin
                errors++;
                $display("FAIL sub_borrow: got res=%h flags=%b expected %h 1001",
                         obs_q[1].result, obs_q[1].flags, ones);
            end
        end
        drain();
    endtask

    task automatic test_back_pressure();
        int  idx;
        int  leaks;
        int  n;
        logic acc;
        clear_q();
        rsp_ready = 1'b0;
        idx   = 0;
        leaks = 0;
        set_rand_cmd(4'd0);
        cmd_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            acc = cmd_ready;
            if (idx >= DEPTH && cmd_ready) leaks++;
            tick();
            if (acc) begin
                idx++;
                if (idx < 10) set_rand_cmd(4'(idx));
                else cmd_valid = 1'b0;
            end
        end
        checks++;
        if (idx !== DEPTH || cmd_ready !== 1'b0 || leaks !== 0) begin
            errors++;
            $display("FAIL bp_stall: got accepted=%0d ready=%b leaks=%0d expected %0d 0 0",
                     idx, cmd_ready, leaks, DEPTH);
        end
        rsp_ready = 1'b1;
        n = 0;
        while (idx < 10 && n < 60) begin
            acc = cmd_ready;
            tick();
            n++;
            if (acc) begin
                idx++;
                if (idx < 10) set_rand_cmd(4'(idx));
                else cmd_valid = 1'b0;
            end
        end
        cmd_valid = 1'b0;
        drain();
        checks++;
        if (obs_q.size() !== 10 || exp_q.size() !== 10) begin
            errors++;
            $display("FAIL bp_count: got %0d responses (%0d issued) expected 10",
                     obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i].tag !== 4'(i)) begin
                errors++;
                $display("FAIL bp_order[%0d]: got tag %0d expected %0d", i, obs_q[i].tag, i);
            end
            if (i < exp_q.size()) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL bp_rsp[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_streaming();
        logic [3:0] ops [4];
        int stalls;
        ops[0] = 4'd3;
        ops[1] = 4'd2;
        ops[2] = 4'd5;
        ops[3] = 4'd7;
        apply_reset();
        rsp_ready = 1'b1;
        stalls = 0;
        for (int i = 0; i < 32; i++) begin
            set_cmd(ops[i % 4], rand128(), (i == 7 || i == 23) ? W'(0) : rand128(),
                    5'($urandom_range(0, 31)), 4'(i));
            cmd_valid = 1'b1;
            if (!cmd_ready) stalls++;
            tick();
        end
        cmd_valid = 1'b0;
        drain();
        checks++;
        if (stalls !== 0 || issue_count !== 16'd32) begin
            errors++;
            $display("FAIL stream_issue: got stalls=%0d issue_count=%0d expected 0 32",
                     stalls, issue_count);
        end
        checks++;
        if (obs_q.size() !== 32 || exp_q.size() !== 32) begin
            errors++;
            $display("FAIL stream_count: got %0d responses (%0d issued) expected 32",
                     obs_q.size(), exp_q.size());
        end else begin
            checks++;
            if ({obs_q[7].result, obs_q[7].flags[2], obs_q[23].result, obs_q[23].flags[2]}
                    !== {W'(0), 1'b1, W'(0), 1'b1}) begin
                errors++;
                $display("FAIL stream_div0: got res=%h z=%b res=%h z=%b expected 0 1 0 1",
                         obs_q[7].result, obs_q[7].flags[2], obs_q[23].result, obs_q[23].flags[2]);
            end
            for (int i = 0; i < 32; i++) begin
                checks++;
                if (obs_q[i] !== exp_q[i] || pop_cyc_q[i] - iss_cyc_q[i] !== LAT + 2) begin
                    errors++;
                    $display("FAIL stream_rsp[%0d]: got %h after %0d edges expected %h after %0d",
                             i, obs_q[i], pop_cyc_q[i] - iss_cyc_q[i], exp_q[i], LAT + 2);
                end
            end
        end
    endtask

    task automatic test_simultaneous();
        rsp_t snap;
        logic snap_valid;
        clear_q();
        snap_valid = 1'b0;
        snap = '0;
        for (int c = 0; c < 300; c++) begin
            checks++;
            if (cmd_ready !== (model_credit < DEPTH)) begin
                errors++;
                $display("FAIL sim_ready[%0d]: got %b expected %b (credit %0d)",
                         c, cmd_ready, model_credit < DEPTH, model_credit);
            end
            if (snap_valid) begin
                checks++;
                if (rsp_valid !== 1'b1 || {rsp_result, rsp_flags, rsp_tag, rsp_opcode} !== snap) begin
                    errors++;
                    $display("FAIL sim_hold[%0d]: got v=%b %h expected 1 %h", c, rsp_valid,
                             {rsp_result, rsp_flags, rsp_tag, rsp_opcode}, snap);
                end
            end
            rsp_ready = 1'($urandom_range(0, 1));
            cmd_valid = ($urandom_range(0, 3) != 0);
            set_rand_cmd(4'($urandom_range(0, 15)));
            snap_valid = rsp_valid && !rsp_ready;
            snap = {rsp_result, rsp_flags, rsp_tag, rsp_opcode};
            tick();
        end
        cmd_valid = 1'b0;
        checks++;
        if (n_both == 0) begin
            errors++;
            $display("FAIL sim_both: got %0d push+pop cycles expected at least 1", n_both);
        end
        drain();
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL sim_count: got %0d responses expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL sim_rsp[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        int ghosts;
        rsp_ready = 1'b1;
        set_rand_cmd(4'd1);
        cmd_valid = 1'b1;
        tick();
        set_rand_cmd(4'd2);
        tick();
        cmd_valid = 1'b0;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        checks++;
        if (cmd_ready !== 1'b1 || issue_count !== 16'd0) begin
            errors++;
            $display("FAIL midrst_state: got ready=%b count=%0d expected 1 0", cmd_ready, issue_count);
        end
        ghosts = 0;
        for (int c = 0; c < 8; c++) begin
            if (rsp_valid !== 1'b0) ghosts++;
            tick();
        end
        checks++;
        if (ghosts !== 0) begin
            errors++;
            $display("FAIL midrst_ghost: got %0d cycles with rsp_valid expected 0", ghosts);
        end
        clear_q();
        send_cmd(4'd0, rand128(), rand128(), 5'd0, 4'd9);
        lat = 0;
        while (!rsp_valid && lat < 10) begin
            tick();
            lat++;
        end
        checks++;
        if (lat !== LAT + 1) begin
            errors++;
            $display("FAIL midrst_latency: got %0d cycles expected %0d", lat, LAT + 1);
        end
        drain();
        checks++;
        if (obs_q.size() !== 1 || exp_q.size() !== 1) begin
            errors++;
            $display("FAIL midrst_count: got %0d responses expected 1", obs_q.size());
        end else begin
            checks++;
            if (obs_q[0] !== exp_q[0]) begin
                errors++;
                $display("FAIL midrst_rsp: got %h expected %h", obs_q[0], exp_q[0]);
            end
        end
    endtask

    initial begin
        rst       = 1'b0;
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        set_cmd(4'd0, '0, '0, 5'd0, 4'd0);
        test_reset();
        test_add_carry();
        test_sub();
        test_back_pressure();
        test_streaming();
        test_simultaneous();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
